// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer.
//
// Contents:
//   sel_e      - per-edge next-PC source select, one code per priority winner.
//   sel_decode - resolves the control inputs into a single select using the
//                fixed priority stall > ret > call > branch > sequential > hold.
package seq_pkg;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_SEQ  = 3'd1,
        SEL_BR   = 3'd2,
        SEL_CALL = 3'd3,
        SEL_RET  = 3'd4
    } sel_e;

    function automatic sel_e sel_decode(
        input logic stall,
        input logic ret_en,
        input logic call_en,
        input logic branch_en,
        input logic nxinst
    );
        sel_e sel;
        if (stall) begin
            sel = SEL_HOLD;
        end else if (ret_en) begin
            sel = SEL_RET;
        end else if (call_en) begin
            sel = SEL_CALL;
        end else if (branch_en) begin
            sel = SEL_BR;
        end else if (nxinst) begin
            sel = SEL_SEQ;
        end else begin
            sel = SEL_HOLD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack, circular, RAS_DEPTH entries of PC_W bits.
//
// Ports:
//   clk, rst_n  - clock (rising edge) and asynchronous active-low reset
//   push        - write push_data as the new top; when full the oldest entry
//                 is overwritten and count saturates at RAS_DEPTH
//   pop         - discard the top entry (ignored when empty)
//   push_data   - return address to push
//   top         - current top entry (meaningless while empty)
//   count       - number of valid entries, 0..RAS_DEPTH
//   full, empty - occupancy flags decoded from the registered count
//
// push and pop are never asserted together by the sequencer; push wins if so.
module ras_stack #(
    parameter int PC_W      = 8,
    parameter int RAS_DEPTH = 4,
    parameter int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [PC_W-1:0]  push_data,
    output logic [PC_W-1:0]  top,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    // wr_ptr_q points at the slot the next push writes. Because the depth is a
    // power of two the pointer wraps naturally, and when the stack is full
    // that slot holds the oldest entry, giving the overwrite-oldest behaviour.
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PC_W-1:0]  mem [RAS_DEPTH];

    assign rd_ptr = wr_ptr_q - PTR_W'(1);
    assign top    = mem[rd_ptr];
    assign count  = count_q;
    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(RAS_DEPTH));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (!full) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr_d = rd_ptr;
            count_d  = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; entries are only read while count > 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program counter sequencer with a return-address stack.
//
// Ports:
//   cout                 - clock, rising edge
//   rst_n                - asynchronous active-low reset
//   nxinst               - advance PC by STEP (wraps at 2^PC_W)
//   stall                - freeze PC, stack and error flag
//   branch_en, branch_pc - redirect PC
//   call_en, call_pc     - jump to call_pc, push PC+STEP
//   ret_en               - pop the stack into PC
//   PC                   - registered program counter
//   ras_empty, ras_full  - stack occupancy, decoded from registered count
//   ras_err              - sticky overflow/underflow flag, cleared only by reset
//
// All controls take effect on the next rising edge of cout; PC is a pure
// register output so there is no combinational input-to-PC path.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int RESET_VEC = 0,
    parameter int STEP      = 1,
    parameter int RAS_DEPTH = 4
) (
    input  logic            cout,
    input  logic            rst_n,
    input  logic            nxinst,
    input  logic            stall,
    input  logic            branch_en,
    input  logic [PC_W-1:0] branch_pc,
    input  logic            call_en,
    input  logic [PC_W-1:0] call_pc,
    input  logic            ret_en,
    output logic [PC_W-1:0] PC,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_err
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    sel_e             sel;
    logic [PC_W-1:0]  pc_d;
    logic [PC_W-1:0]  pc_seq;
    logic             err_d;
    logic             push;
    logic             pop;
    logic [PC_W-1:0]  top;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    // Truncation to PC_W bits gives the silent modulo wrap.
    assign pc_seq = PC + PC_W'(STEP);
    assign sel    = sel_decode(stall, ret_en, call_en, branch_en, nxinst);

    always_comb begin
        pc_d  = PC;
        err_d = ras_err;
        push  = 1'b0;
        pop   = 1'b0;
        unique case (sel)
            SEL_RET: begin
                if (!empty) begin
                    pc_d = top;
                    pop  = 1'b1;
                end else begin
                    // Underflow: PC holds, flag the error.
                    err_d = 1'b1;
                end
            end
            SEL_CALL: begin
                pc_d = call_pc;
                push = 1'b1;
                if (full) begin
                    err_d = 1'b1;
                end
            end
            SEL_BR:   pc_d = branch_pc;
            SEL_SEQ:  pc_d = pc_seq;
            default:  pc_d = PC;
        endcase
    end

    always_ff @(posedge cout or negedge rst_n) begin
        if (!rst_n) begin
            PC      <= PC_W'(RESET_VEC);
            ras_err <= 1'b0;
        end else begin
            PC      <= pc_d;
            ras_err <= err_d;
        end
    end

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH),
        .CNT_W     (CNT_W)
    ) u_ras_stack (
        .clk       (cout),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_seq),
        .top       (top),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign ras_empty = (count == '0);
    assign ras_full  = (count == CNT_W'(RAS_DEPTH));

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 The module SHALL have parameter PC_W, default 8, meaning program-counter width in bits.
REQ-002 The module SHALL have parameter RESET_VEC, default 0, meaning PC value loaded at reset.
REQ-003 The module SHALL have parameter STEP, default 1, meaning sequential increment per advance.
REQ-004 The module SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of two, >=2).
REQ-005 The module SHALL have port cout, input, 1 bit: sole clock, rising-edge active.
REQ-006 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The module SHALL have port nxinst, input, 1 bit: advance PC sequentially.
REQ-008 The module SHALL have port stall, input, 1 bit: freeze PC and stack.
REQ-009 The module SHALL have ports branch_en (input, 1 bit) and branch_pc (input, PC_W bits): redirect PC to branch_pc.
REQ-010 The module SHALL have ports call_en (input, 1 bit) and call_pc (input, PC_W bits): jump to call_pc and push the return address.
REQ-011 The module SHALL have port ret_en, input, 1 bit: pop the stack into PC.
REQ-012 The module SHALL have port PC, output reg, PC_W bits: current program counter.
REQ-013 The module SHALL have ports ras_empty and ras_full, output, 1 bit each: stack occupancy flags.
REQ-014 The module SHALL have port ras_err, output, 1 bit: sticky stack overflow/underflow flag.

Function
REQ-015 All state SHALL update only on rising cout; a control sampled at edge N SHALL be visible on PC after edge N (one-cycle latency).
REQ-016 Per-edge priority SHALL be: stall > ret_en > call_en > branch_en > nxinst > hold.
REQ-017 stall=1 SHALL hold PC, stack contents, count and ras_err unchanged, regardless of other inputs.
REQ-018 ret_en with stack non-empty SHALL load PC with the top entry and decrement count.
REQ-019 ret_en with stack empty SHALL hold PC, leave count at 0 and set ras_err.
REQ-020 call_en SHALL load PC with call_pc and push (PC+STEP) mod 2^PC_W.
REQ-021 call_en with stack full SHALL overwrite the oldest entry (circular), keep count at RAS_DEPTH and set ras_err.
REQ-022 branch_en SHALL load PC with branch_pc; the stack SHALL be unchanged.
REQ-023 nxinst alone SHALL load PC with (PC+STEP) mod 2^PC_W, wrapping silently at the top of the address space.
REQ-024 With no control asserted, PC SHALL hold.
REQ-025 ras_empty SHALL equal (count==0) and ras_full SHALL equal (count==RAS_DEPTH), both combinational from registered count.
REQ-026 ras_err SHALL remain 1 once set until reset.

Reset
REQ-027 rst_n low SHALL immediately set PC=RESET_VEC, count=0, ras_err=0, ras_empty=1 and ras_full=0, independent of cout.
REQ-028 Stack entry contents SHALL need no reset; they SHALL be unobservable while count is 0.
REQ-029 Reset asserted mid-call or mid-return SHALL abandon the operation, with the first post-reset edge obeying REQ-016 from the reset state.

Structure
REQ-030 The priority-select encoding (SEL_HOLD, SEL_SEQ, SEL_BR, SEL_CALL, SEL_RET) SHALL live in shared package seq_pkg.
REQ-031 The return-address stack SHALL be a sub-module named ras_stack (push, pop, top, count, full, empty), parametrised by PC_W and RAS_DEPTH.
REQ-032 The design SHALL contain no latches and no combinational path from inputs to PC.

Verification (PC_W=8, STEP=1, RESET_VEC=0, RAS_DEPTH=4)
REQ-033 Reset, then nxinst=1 for 3 edges -> PC 0,1,2,3; ras_empty=1.
REQ-034 PC=0xFF, nxinst=1 -> PC=0x00 and no error.
REQ-035 PC=0x10, call_en with call_pc=0x40, then ret_en -> PC=0x40 then 0x11; ras_empty=1, ras_err=0.
REQ-036 5 calls from PC=0x01 with call_pc=0x20,0x30,0x40,0x50,0x60 -> ras_full=1, ras_err=1; 4 returns yield 0x51,0x41,0x31,0x21; a 5th return holds PC.
REQ-037 stall=1 with ret_en=1, call_en=1 and nxinst=1 -> PC and count unchanged; branch_en with call_en (call_pc=0x40, branch_pc=0x80) -> call wins, PC=0x40.
REQ-038 Assert rst_n low between edges with count=2 and PC=0x33 -> PC=0x00 and ras_empty=1 immediately, before the next edge.
